frame_gen: RTL

FRAME_GEN -- requirements
Module: frame_gen

---
 rtl/frame_gen_pkg.sv | 20 ++
 rtl/frame_checksum.sv | 20 ++
 rtl/frame_gen.sv | 103 ++++++++++
 3 files changed

// File: rtl/frame_gen_pkg.sv
// Shared types and sizing helpers for the frame generator.
package frame_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Total frame width: header + payload fields + checksum.
    function automatic int frame_w(input int n_fields, input int field_w);
        return (n_fields + 2) * field_w;
    endfunction

    // Number of output symbols needed to carry one frame.
    function automatic int sym_count(input int n_fields, input int field_w, input int sym_w);
        return frame_w(n_fields, field_w) / sym_w;
    endfunction

endpackage

// File: rtl/frame_checksum.sv
// Combinational modular sum of all payload fields.
module frame_checksum
    import frame_gen_pkg::*;
#(
    parameter int N_FIELDS = 3,
    parameter int FIELD_W  = 8
) (
    input  logic [N_FIELDS*FIELD_W-1:0] fields,
    output logic [FIELD_W-1:0]          csum
);

    // Sum wraps naturally at FIELD_W bits.
    always_comb begin
        csum = '0;
        for (int i = 0; i < N_FIELDS; i++) begin
            csum = csum + fields[i*FIELD_W +: FIELD_W];
        end
    end

endmodule

// File: rtl/frame_gen.sv
// Frame generator: latches {HEADER, fields, CSUM} and streams it out
// MSB-first as SYM_W-bit symbols over a valid/ready handshake.
module frame_gen
    import frame_gen_pkg::*;
#(
    parameter int                 N_FIELDS = 3,
    parameter int                 FIELD_W  = 8,
    parameter logic [FIELD_W-1:0] HEADER   = 8'hCC,
    parameter int                 SYM_W    = 2,
    parameter int                 GAP_CYC  = 0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [N_FIELDS*FIELD_W-1:0]       fields_i,
    input  logic                              start_i,
    output logic [(N_FIELDS+2)*FIELD_W-1:0]   para_o,
    output logic [SYM_W-1:0]                  sym_o,
    output logic                              sym_valid_o,
    input  logic                              sym_ready_i,
    output logic                              busy_o,
    output logic                              frame_done_o
);

    localparam int FRAME_W = frame_w(N_FIELDS, FIELD_W);
    localparam int NSYM    = sym_count(N_FIELDS, FIELD_W, SYM_W);
    // Extra bit so the counter reaches NSYM without wrapping.
    localparam int CNT_W   = $clog2(NSYM) + 1;

    state_t             state, state_nxt;
    logic [FRAME_W-1:0] shreg;
    logic [FRAME_W-1:0] frame;
    logic [CNT_W-1:0]   sym_cnt;
    logic [7:0]         gap_cnt;
    logic [FIELD_W-1:0] csum;
    logic               hs;
    logic               last_sym;
    logic               gap_end;

    frame_checksum #(
        .N_FIELDS (N_FIELDS),
        .FIELD_W  (FIELD_W)
    ) u_csum (
        .fields (fields_i),
        .csum   (csum)
    );

    assign frame       = {HEADER, fields_i, csum};
    assign hs          = sym_valid_o & sym_ready_i;
    assign last_sym    = (sym_cnt == CNT_W'(NSYM - 1));
    assign gap_end     = (gap_cnt == 8'(GAP_CYC - 1));
    assign sym_o       = shreg[FRAME_W-1 -: SYM_W];
    assign sym_valid_o = (state == SEND);
    assign busy_o      = (state != IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; start_i only matters in IDLE, so requests in SEND/GAP drop.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start_i) state_nxt = SEND;
            SEND: if (hs && last_sym) state_nxt = (GAP_CYC == 0) ? IDLE : GAP;
            GAP:  if (gap_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: frame latch, symbol shifting, counters and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg        <= '0;
            para_o       <= '0;
            sym_cnt      <= '0;
            gap_cnt      <= '0;
            frame_done_o <= 1'b0;
        end else begin
            frame_done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        shreg   <= frame;
                        para_o  <= frame;
                        sym_cnt <= '0;
                    end
                end
                SEND: begin
                    if (hs) begin
                        shreg   <= shreg << SYM_W;
                        sym_cnt <= sym_cnt + CNT_W'(1);
                        if (last_sym) frame_done_o <= 1'b1;
                    end
                end
                default: ;
            endcase
            gap_cnt <= (state == GAP) ? gap_cnt + 8'd1 : 8'd0;
        end
    end

endmodule
